// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline sequencer and the pipeline: stall requests and
// redirect sources in, pause/flush/PC redirect and stall statistics out.
interface pipeline_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              stall_req_if;
  logic              stall_req_id;
  logic              stall_req_ex;
  logic              stall_req_mem;
  logic              except_valid_i;
  logic [ADDR_W-1:0] except_target_i;
  logic              ertn_valid_i;
  logic [ADDR_W-1:0] ertn_target_i;
  logic              branch_valid_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [5:0]        pause_o;
  logic              flush_o;
  logic              is_branch_o;
  logic [ADDR_W-1:0] branch_target_o;
  logic [CNT_W-1:0]  stall_cycles_o;

  modport master (
    output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
    output except_valid_i, except_target_i, ertn_valid_i, ertn_target_i,
    output branch_valid_i, branch_target_i,
    input  pause_o, flush_o, is_branch_o, branch_target_o, stall_cycles_o
  );

  modport slave (
    input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
    input  except_valid_i, except_target_i, ertn_valid_i, ertn_target_i,
    input  branch_valid_i, branch_target_i,
    output pause_o, flush_o, is_branch_o, branch_target_o, stall_cycles_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stall requests into pause, prioritises redirects
// (exception > ertn > branch > pending) and holds a branch while the PC is paused.
//
// state | meaning
// IDLE  | no redirect waiting; redirects go straight to the PC when it is not paused
// PEND  | a branch target is parked in pend_target until the PC is released
module pipeline_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pend_target_nxt;
  logic [CNT_W-1:0]  stall_cnt;

  logic [5:0]        stall_pause;
  logic [5:0]        pause;
  logic              flush;
  logic              is_branch;
  logic [ADDR_W-1:0] target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (pause[0] && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    stall_pause     = 6'b000000;
    flush           = bus.except_valid_i | bus.ertn_valid_i;
    state_nxt       = state;
    pend_target_nxt = pend_target;
    is_branch       = 1'b0;
    target          = '0;

    // The deepest stalling stage holds itself and everything upstream of it.
    if (bus.stall_req_mem)     stall_pause = 6'b011111;
    else if (bus.stall_req_ex) stall_pause = 6'b001111;
    else if (bus.stall_req_id) stall_pause = 6'b000111;
    else if (bus.stall_req_if) stall_pause = 6'b000011;

    pause = flush ? 6'b000000 : stall_pause;

    case (state)
      IDLE: begin
        if (flush) begin
          is_branch = 1'b1;
          target    = bus.except_valid_i ? bus.except_target_i : bus.ertn_target_i;
        end else if (bus.branch_valid_i) begin
          if (!pause[0]) begin
            is_branch = 1'b1;
            target    = bus.branch_target_i;
          end else begin
            pend_target_nxt = bus.branch_target_i;
            state_nxt       = PEND;
          end
        end
      end
      PEND: begin
        if (flush) begin
          is_branch       = 1'b1;
          target          = bus.except_valid_i ? bus.except_target_i : bus.ertn_target_i;
          pend_target_nxt = '0;
          state_nxt       = IDLE;
        end else if (!pause[0]) begin
          is_branch = 1'b1;
          target    = bus.branch_valid_i ? bus.branch_target_i : pend_target;
          state_nxt = IDLE;
        end else if (bus.branch_valid_i) begin
          pend_target_nxt = bus.branch_target_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pause_o         = pause;
  assign bus.flush_o         = flush;
  assign bus.is_branch_o     = is_branch;
  assign bus.branch_target_o = target;
  assign bus.stall_cycles_o  = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: vector table, directed corner sequences and
// randomized traffic against a pending-flag reference model (CNT_W = 4).
module tb_pipeline_ctrl;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [31:0] ET = 32'h1C00_8000;
  localparam logic [31:0] RT = 32'h1C00_1234;
  localparam logic [31:0] BT = 32'h1C00_0040;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  st   = 4'b0;
  logic        ex_v = 1'b0, er_v = 1'b0, br_v = 1'b0;
  logic [31:0] ex_t = '0, er_t = '0, br_t = '0;

  int n_chk  = 0;
  int n_fail = 0;

  logic        m_pend = 1'b0, nx_pend;
  logic [31:0] m_pt = '0, nx_pt;
  int          m_cnt = 0, nx_cnt;

  pipeline_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  assign bus.stall_req_if    = st[0];
  assign bus.stall_req_id    = st[1];
  assign bus.stall_req_ex    = st[2];
  assign bus.stall_req_mem   = st[3];
  assign bus.except_valid_i  = ex_v;
  assign bus.except_target_i = ex_t;
  assign bus.ertn_valid_i    = er_v;
  assign bus.ertn_target_i   = er_t;
  assign bus.branch_valid_i  = br_v;
  assign bus.branch_target_i = br_t;

  pipeline_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  stall;
    logic        exc, ert, br;
    logic [5:0]  pause;
    logic        flush, isb;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [3:0] s, logic e, logic r, logic b,
                              logic [5:0] p, logic f, logic i, logic [31:0] t);
    vec_t v;
    v.stall = s; v.exc = e; v.ert = r; v.br = b;
    v.pause = p; v.flush = f; v.isb = i; v.tgt = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    st = 4'b0; ex_v = 1'b0; er_v = 1'b0; br_v = 1'b0;
    ex_t = ET; er_t = RT; br_t = BT;
  endtask

  // Reference: pause mask from the deepest requester, redirect by priority,
  // a single pending flag for a branch that met a paused PC.
  task automatic model_check(input string tag);
    int hi;
    logic [5:0]  ep;
    logic        ef, eb;
    logic [31:0] etg;
    hi = 0;
    for (int i = 1; i <= 4; i++) if (st[i-1]) hi = i;
    ep = (hi == 0) ? 6'b0 : 6'((1 << (hi + 1)) - 1);
    ef = ex_v | er_v;
    if (ef) ep = 6'b0;
    eb = 1'b0; etg = '0; nx_pend = m_pend; nx_pt = m_pt;
    if (ef) begin
      eb = 1'b1; etg = ex_v ? ex_t : er_t; nx_pend = 1'b0;
    end else if (ep[0]) begin
      if (br_v) begin nx_pend = 1'b1; nx_pt = br_t; end
    end else if (br_v) begin
      eb = 1'b1; etg = br_t; nx_pend = 1'b0;
    end else if (m_pend) begin
      eb = 1'b1; etg = m_pt; nx_pend = 1'b0;
    end
    nx_cnt = (ep[0] && m_cnt < 15) ? m_cnt + 1 : m_cnt;
    chk({tag, "_pause"},  64'(bus.pause_o), 64'(ep));
    chk({tag, "_flush"},  64'(bus.flush_o), 64'(ef));
    chk({tag, "_isb"},    64'(bus.is_branch_o), 64'(eb));
    chk({tag, "_target"}, 64'(bus.branch_target_o), 64'(etg));
    chk({tag, "_cnt"},    64'(bus.stall_cycles_o), 64'(m_cnt));
  endtask

  // Inputs are applied at negedge; check 2 time units later, then advance.
  task automatic step_model(input string tag);
    #2;
    model_check(tag);
    @(posedge clk);
    m_pend = nx_pend; m_pt = nx_pt; m_cnt = nx_cnt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    m_pend = 1'b0; m_pt = '0; m_cnt = 0;
    chk("reset_pause", 64'(bus.pause_o), 64'(0));
    chk("reset_isb",   64'(bus.is_branch_o), 64'(0));
    chk("reset_cnt",   64'(bus.stall_cycles_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(4'b0100, 1'b0, 1'b0, 1'b0, 6'b001111, 1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(4'b0001, 1'b0, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(4'b0000, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0);
    vecs[3]  = mk(4'b0010, 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0, 1'b0, 32'h0);
    vecs[4]  = mk(4'b1000, 1'b0, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 32'h0);
    vecs[5]  = mk(4'b1111, 1'b0, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 32'h0);
    vecs[6]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, BT);
    vecs[7]  = mk(4'b0001, 1'b0, 1'b0, 1'b1, 6'b000011, 1'b0, 1'b0, 32'h0);
    vecs[8]  = mk(4'b1111, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, ET);
    vecs[9]  = mk(4'b0000, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b1, RT);
    vecs[10] = mk(4'b0100, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, RT);
    vecs[11] = mk(4'b1000, 1'b1, 1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, ET);

    idle_inputs();
    #1;
    chk("reset_flush",  64'(bus.flush_o), 64'(0));
    chk("reset_target", 64'(bus.branch_target_o), 64'(0));
    @(negedge clk);
    do_reset();

    // Table: each vector followed by an idle cycle that drains any pending branch.
    for (int k = 0; k < 12; k++) begin
      st = vecs[k].stall; ex_v = vecs[k].exc; er_v = vecs[k].ert; br_v = vecs[k].br;
      #2;
      chk($sformatf("vec%0d_pause", k),  64'(bus.pause_o), 64'(vecs[k].pause));
      chk($sformatf("vec%0d_flush", k),  64'(bus.flush_o), 64'(vecs[k].flush));
      chk($sformatf("vec%0d_isb", k),    64'(bus.is_branch_o), 64'(vecs[k].isb));
      chk($sformatf("vec%0d_target", k), 64'(bus.branch_target_o), 64'(vecs[k].tgt));
      #(-2 + 2);
      model_check($sformatf("vec%0d_m", k));
      @(posedge clk);
      m_pend = nx_pend; m_pt = nx_pt; m_cnt = nx_cnt;
      @(negedge clk);
      idle_inputs();
      step_model($sformatf("drain%0d", k));
    end

    // Branch parked behind a 3-cycle MEM stall, issued exactly once.
    do_reset();
    br_v = 1'b1; br_t = 32'h80; st = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("pend_hold%0d_isb", c), 64'(bus.is_branch_o), 64'(0));
      @(negedge clk);
      br_v = 1'b0;
    end
    st = 4'b0;
    #2;
    chk("pend_issue_isb",    64'(bus.is_branch_o), 64'(1));
    chk("pend_issue_target", 64'(bus.branch_target_o), 64'(32'h80));
    @(negedge clk);
    #2;
    chk("pend_once_isb", 64'(bus.is_branch_o), 64'(0));
    chk("pend_cnt",      64'(bus.stall_cycles_o), 64'(3));

    // Exception arriving while a branch is parked discards it.
    do_reset();
    br_v = 1'b1; br_t = 32'h80; st = 4'b1000;
    @(negedge clk);
    br_v = 1'b0; ex_v = 1'b1; ex_t = ET;
    #2;
    chk("exc_pend_flush",  64'(bus.flush_o), 64'(1));
    chk("exc_pend_pause",  64'(bus.pause_o), 64'(0));
    chk("exc_pend_target", 64'(bus.branch_target_o), 64'(ET));
    @(negedge clk);
    ex_v = 1'b0; st = 4'b0;
    #2;
    chk("exc_pend_cleared", 64'(bus.is_branch_o), 64'(0));
    chk("exc_flush_1cyc",   64'(bus.flush_o), 64'(0));

    // Counter saturation at 15, then async reset while a branch is parked.
    do_reset();
    st = 4'b0100;
    for (int c = 0; c < 20; c++) @(negedge clk);
    #2;
    chk("sat_cnt", 64'(bus.stall_cycles_o), 64'(15));
    @(negedge clk);
    br_v = 1'b1; br_t = 32'h1C00_0100; st = 4'b1000;
    @(negedge clk);
    br_v = 1'b0;
    #2;
    st = 4'b0; rst = 1'b0;
    #1;
    chk("rst_mid_isb",    64'(bus.is_branch_o), 64'(0));
    chk("rst_mid_target", 64'(bus.branch_target_o), 64'(0));
    chk("rst_mid_pause",  64'(bus.pause_o), 64'(0));
    chk("rst_mid_cnt",    64'(bus.stall_cycles_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_dropped_isb", 64'(bus.is_branch_o), 64'(0));
    @(negedge clk);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) st[b] = ($urandom_range(3) == 0);
      ex_v = ($urandom_range(19) == 0);
      er_v = ($urandom_range(19) == 0);
      br_v = ($urandom_range(4) == 0);
      ex_t = $urandom; er_t = $urandom; br_t = $urandom;
      step_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
